// File: rtl/spi_wb_master_bridge_if.sv
// SPI pins and Wishbone classic master bus of the SPI-to-Wishbone bridge.
// "master" is the bridge side; "slave" is the flight-controller/peripheral side.
interface spi_wb_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = 4
);
  logic                    spi_sclk;
  logic                    spi_cs_n;
  logic                    spi_mosi;
  logic                    spi_miso;
  logic [ADDR_WIDTH-1:0]   wbm_adr_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_i;
  logic                    wbm_we_o;
  logic [SELECT_WIDTH-1:0] wbm_sel_o;
  logic                    wbm_stb_o;
  logic                    wbm_cyc_o;
  logic                    wbm_ack_i;
  logic                    wbm_err_i;

  modport master (
    input  spi_sclk, spi_cs_n, spi_mosi, wbm_dat_i, wbm_ack_i, wbm_err_i,
    output spi_miso, wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output spi_sclk, spi_cs_n, spi_mosi, wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  spi_miso, wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/spi_wb_master_bridge.sv
// SPI mode-0 slave that turns CMD/ADDR/DATA frames into single 32-bit Wishbone classic cycles.
// SPI is oversampled in the clk domain; the bus cycle runs alongside the remaining SPI bits.
module spi_wb_master_bridge #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WB_TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_wb_master_bridge_if.master bus,
  output logic                   busy_o
);
  localparam int unsigned TO_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [7:0] CMD_RD    = 8'hA1;
  localparam logic [7:0] CMD_WR    = 8'hA2;
  localparam logic [7:0] ST_OK     = 8'h01;
  localparam logic [7:0] ST_FAIL   = 8'hEE;
  localparam logic [7:0] ST_BADCMD = 8'hEC;
  localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RPAD, S_RDATA, S_DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_s_q, cs_s_q, mosi_s_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_n, mosi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s_q    <= '0;
      cs_s_q      <= '1;
      mosi_s_q    <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_s_q    <= {sclk_s_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_s_q      <= {cs_s_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_s_q    <= {mosi_s_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_prev_q <= sclk_s_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_s_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_s_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_n      = cs_s_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_n & cs_prev_q;
  assign mosi      = mosi_s_q[SYNC_STAGES-1];

  state_e                  state_q, state_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              cmd_q, cmd_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d, tx_q, tx_d, rdata_q, rdata_d;
  logic [7:0]              status_q, status_d;
  logic                    stb_q, stb_d, we_q, we_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [7:0]              cmd_byte;

  assign cmd_byte = {cmd_q, mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      is_wr_q   <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      tx_q      <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      is_wr_q   <= is_wr_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      tx_q      <= tx_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    is_wr_d   = is_wr_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    tx_d      = tx_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    stb_d     = stb_q;
    we_d      = we_q;
    to_cnt_d  = to_cnt_q;

    // Bus cycle runs independently of CS so an abandoned frame's cycle still completes.
    if (stb_q) begin
      if (bus.wbm_ack_i) begin
        stb_d = 1'b0; we_d = 1'b0; rdata_d = bus.wbm_dat_i; status_d = ST_OK;
      end else if (bus.wbm_err_i || to_cnt_q == TO_W'(WB_TIMEOUT - 1)) begin
        stb_d = 1'b0; we_d = 1'b0; rdata_d = DEAD; status_d = ST_FAIL;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (cs_n) begin
      state_d = S_IDLE;
    end else if (cs_fall) begin
      bit_cnt_d = '0;
      // A frame starting while the previous cycle is still in flight is ignored.
      if (stb_q) begin
        tx_d    = '0;
        state_d = S_DONE;
      end else begin
        tx_d    = {status_q, {(DATA_WIDTH-8){1'b0}}};
        state_d = S_CMD;
      end
    end else begin
      if (sclk_fall) begin
        // First RDATA fall loads read data instead of shifting; a late cycle is abandoned.
        if (state_q == S_RDATA && bit_cnt_q == 6'd0) begin
          if (stb_q) begin
            tx_d = DEAD; stb_d = 1'b0; we_d = 1'b0; status_d = ST_FAIL;
          end else begin
            tx_d = rdata_q;
          end
        end else begin
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        unique case (state_q)
          S_CMD: begin
            cmd_d = cmd_byte[6:0];
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = '0;
              if (cmd_byte == CMD_WR || cmd_byte == CMD_RD) begin
                is_wr_d = (cmd_byte == CMD_WR);
                state_d = S_ADDR;
              end else begin
                status_d = ST_BADCMD;
                state_d  = S_DONE;
              end
            end
          end
          S_ADDR: begin
            adr_d = {adr_q[ADDR_WIDTH-2:0], mosi};
            if (bit_cnt_q == 6'd31) begin
              bit_cnt_d = '0;
              if (is_wr_q) begin
                state_d = S_WDATA;
              end else begin
                stb_d = 1'b1; we_d = 1'b0; to_cnt_d = '0;
                state_d = S_RPAD;
              end
            end
          end
          S_WDATA: begin
            wdat_d = {wdat_q[DATA_WIDTH-2:0], mosi};
            if (bit_cnt_q == 6'd31) begin
              bit_cnt_d = '0;
              stb_d = 1'b1; we_d = 1'b1; to_cnt_d = '0;
              state_d = S_DONE;
            end
          end
          S_RPAD: begin
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = '0;
              state_d   = S_RDATA;
            end
          end
          S_RDATA: begin
            if (bit_cnt_q == 6'd31) begin
              bit_cnt_d = '0;
              state_d   = S_DONE;
            end
          end
          default: bit_cnt_d = bit_cnt_q;
        endcase
      end
    end
  end

  assign bus.spi_miso  = tx_q[DATA_WIDTH-1];
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = wdat_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = {SELECT_WIDTH{stb_q}};
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_cyc_o = stb_q;
  assign busy_o        = ~cs_n | stb_q;
endmodule
